comparator_search_ctrl: RTL and testbench
=========================================

Name: comparator_search_ctrl

Overview:
- Sequential binary-search controller wrapped around the 4-bit magnitude comparator (Eq/Gt/St).
- Comparator A is driven by an external target value; B is driven by this block's registered `guess`.
- Each probe reads the comparator flags and narrows a [lo,hi] window. It reports the found value and the probe count, or reports not-found / flag error.

Parameters:
- WIDTH, 4, operand width; search range is 0 to 2^WIDTH-1.
- SETTLE, 0, extra wait cycles after each new guess before flags are sampled (0..7).
- STEPW, $clog2(WIDTH+2), width of the probe counter (3 for WIDTH=4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin search; sampled only in IDLE or DONE
- Eq  input  1  comparator A==B (target == guess)
- Gt  input  1  comparator A>B (target > guess)
- St  input  1  comparator A<B (target < guess)
- guess  output  WIDTH  registered probe value; drives comparator B
- busy  output  1  high in WAIT state
- done  output  1  high in DONE state (level, held until restart or reset)
- found  output  1  valid with done: target located
- err  output  1  valid with done: flags were not one-hot at a sample
- result  output  WIDTH  located value; valid when done&found, else 0
- steps  output  STEPW  number of evaluated probes in the last or current search

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; guess, result, steps, lo, hi and cnt all 0; busy, done, found and err all 0. Reset has priority over every other event, including mid-search and coincident start.
- States: IDLE, WAIT, DONE. Internal registers: lo and hi (WIDTH bits), cnt (3 bits).
- IDLE or DONE, start=1:
  - next state WAIT; lo=0; hi=2^WIDTH-1; guess=(2^WIDTH-1)>>1 (7 for WIDTH=4).
  - cnt=0; steps=0; done, found and err cleared; result=0.
- WAIT, cnt<SETTLE: cnt+=1; flags ignored.
- WAIT, cnt==SETTLE: evaluate flags this cycle and set steps+=1. Exactly one of the following applies:
  - Flags not one-hot (none set or more than one set): DONE with err=1, found=0.
  - Eq: DONE with found=1, result=guess.
  - Gt and guess==hi: DONE with found=0 (window exhausted; no overflow).
  - Gt otherwise: lo=guess+1; guess=(guess+1+hi)>>1; cnt=0; remain in WAIT.
  - St and guess==lo: DONE with found=0 (no underflow).
  - St otherwise: hi=guess-1; guess=(lo+guess-1)>>1; cnt=0; remain in WAIT.
- Midpoint sums are computed at WIDTH+1 bits, then shifted. lo, hi and guess never wrap.
- start while in WAIT is ignored.
- In DONE, guess holds its last probe value.
- Timing:
  - Each probe costs SETTLE+1 cycles.
  - done rises N*(SETTLE+1)+1 cycles after the start edge, where N is the final steps value.
  - With WIDTH=4, N is at most 5 when the comparator is consistent.
- busy = (state==WAIT); done = (state==DONE). Both are registered outputs.

Test Plan:
1. SETTLE=0, target A=7, pulse start -> guess=7; done, found=1, result=7, steps=1 two cycles after start; busy high exactly 1 cycle.
2. SETTLE=0, A=15 -> guess sequence 7,11,13,14,15; found=1, result=15, steps=5, done at cycle 6.
3. SETTLE=0, A=0 -> guesses 7,3,1,0; found=1, result=0, steps=4. Then force St=1 at guess 0 (flags Eq=0, Gt=0, St=1) -> found=0, err=0, no underflow.
4. Force Eq=1 and Gt=1 at the first sample -> done, err=1, found=0, steps=1. Force all flags 0 -> same response.
5. SETTLE=2, A=10 -> guesses 7,11,9,10, each held 3 cycles; steps=4; done at cycle 13. A start pulse during the search changes nothing.
6. rst=1 on the 3rd probe of an A=15 search -> next cycle all outputs 0, state IDLE. A following start restarts cleanly at guess=7.

Source files
------------

// File: rtl/comparator_search_ctrl.sv
// Binary-search controller that drives comparator operand B with a registered
// guess and narrows a [lo,hi] window from the comparator's Eq/Gt/St flags
// until the target is located, the window is exhausted, or the flags are
// inconsistent.
module comparator_search_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0,
  parameter int STEPW  = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Eq,
  input  logic             Gt,
  input  logic             St,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [STEPW-1:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MID_INIT = MAX_VAL >> 1;
  localparam logic [2:0]       SETTLE_C = 3'(SETTLE);

  state_t             state_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   guess_q;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         cnt_q;
  logic [STEPW-1:0]   steps_q;
  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic               err_q;

  // Midpoints are formed one bit wider than the operands so the sum of two
  // WIDTH-bit values cannot wrap before the halving shift.
  logic [WIDTH:0]     up_sum_d;
  logic [WIDTH:0]     dn_sum_d;
  logic [WIDTH-1:0]   up_mid_d;
  logic [WIDTH-1:0]   dn_mid_d;
  logic               one_hot_d;

  // Candidate next guesses for the "target above" and "target below" cases.
  always_comb begin
    up_sum_d  = {1'b0, guess_q} + {1'b0, hi_q} + (WIDTH + 1)'(1);
    dn_sum_d  = {1'b0, lo_q} + {1'b0, guess_q} - (WIDTH + 1)'(1);
    up_mid_d  = WIDTH'(up_sum_d >> 1);
    dn_mid_d  = WIDTH'(dn_sum_d >> 1);
    one_hot_d = ({Eq, Gt, St} == 3'b100) ||
                ({Eq, Gt, St} == 3'b010) ||
                ({Eq, Gt, St} == 3'b001);
  end

  // Search FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_WAIT;
            lo_q     <= '0;
            hi_q     <= MAX_VAL;
            guess_q  <= MID_INIT;
            result_q <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt_q != SETTLE_C) begin
            // Give the comparator time to settle on the new guess.
            cnt_q <= cnt_q + 3'd1;
          end else begin
            steps_q <= steps_q + STEPW'(1);
            if (!one_hot_d) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (Eq) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              found_q  <= 1'b1;
              result_q <= guess_q;
            end else if (Gt) begin
              if (guess_q == hi_q) begin
                // Nothing left above the guess: stop rather than wrap.
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                lo_q    <= guess_q + WIDTH'(1);
                guess_q <= up_mid_d;
                cnt_q   <= '0;
              end
            end else begin
              if (guess_q == lo_q) begin
                // Nothing left below the guess: stop rather than wrap.
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                hi_q    <= guess_q - WIDTH'(1);
                guess_q <= dn_mid_d;
                cnt_q   <= '0;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Directed bench: two controllers (SETTLE=0 and SETTLE=2), each wrapped by a
// behavioural 4-bit comparator whose flags can be overridden per test.
module tb_comparator_search_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v   [2];
  logic [3:0] target_v  [2];
  logic       force_all [2];
  logic [2:0] force_val [2];   // {Eq,Gt,St}
  logic       force_zero[2];   // report St whenever guess==0
  logic [2:0] flags     [2];

  logic [3:0] guess_w [2];
  logic [3:0] result_w[2];
  logic [2:0] steps_w [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       found_w [2];
  logic       err_w   [2];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] gseen[$];
  int         cyc;
  int         busy_cnt;
  logic       first_done, first_found;
  logic [3:0] first_result;

  always #5 clk = ~clk;

  // Comparator model, optionally overridden.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flags[i] = {target_v[i] == guess_w[i], target_v[i] > guess_w[i], target_v[i] < guess_w[i]};
      if (force_all[i])
        flags[i] = force_val[i];
      else if (force_zero[i] && guess_w[i] == 4'd0)
        flags[i] = 3'b001;
    end
  end

  comparator_search_ctrl #(.WIDTH(4), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .Eq(flags[0][2]), .Gt(flags[0][1]), .St(flags[0][0]),
    .guess(guess_w[0]), .busy(busy_w[0]), .done(done_w[0]), .found(found_w[0]),
    .err(err_w[0]), .result(result_w[0]), .steps(steps_w[0])
  );

  comparator_search_ctrl #(.WIDTH(4), .SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .Eq(flags[1][2]), .Gt(flags[1][1]), .St(flags[1][0]),
    .guess(guess_w[1]), .busy(busy_w[1]), .done(done_w[1]), .found(found_w[1]),
    .err(err_w[1]), .result(result_w[1]), .steps(steps_w[1])
  );

  // Pulse start on instance s and follow the search until done (bounded).
  task automatic do_search(input int s, input bit mid_start);
    gseen.delete();
    busy_cnt = 0;
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    cyc = 1;
    first_done   = done_w[s];
    first_found  = found_w[s];
    first_result = result_w[s];
    while (!done_w[s] && cyc < 60) begin
      gseen.push_back(guess_w[s]);
      if (busy_w[s]) busy_cnt++;
      start_v[s] = mid_start && (cyc == 4);
      @(negedge clk);
      cyc++;
    end
    start_v[s] = 1'b0;
    $display("[TB] search inst=%0d target=%0d cycles=%0d done=%0b found=%0b err=%0b result=%0d steps=%0d guess=%0d",
             s, target_v[s], cyc, done_w[s], found_w[s], err_w[s], result_w[s], steps_w[s], guess_w[s]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      tests_run++;
      if ({guess_w[s], result_w[s], steps_w[s], busy_w[s], done_w[s], found_w[s], err_w[s]} !== 15'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs inst=%0d got guess=%0d result=%0d steps=%0d busy=%0b done=%0b found=%0b err=%0b want all 0",
                 s, guess_w[s], result_w[s], steps_w[s], busy_w[s], done_w[s], found_w[s], err_w[s]);
      end
    end
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset with coincident start checked");
  endtask

  task automatic test_first_hit();
    target_v[0] = 4'd7;
    do_search(0, 1'b0);
    tests_run++;
    if ({done_w[0], found_w[0], err_w[0]} !== 3'b110) begin
      tests_failed++;
      $display("FAIL hit7_flags got done/found/err=%b want 110", {done_w[0], found_w[0], err_w[0]});
    end
    tests_run++;
    if (result_w[0] !== 4'd7 || steps_w[0] !== 3'd1) begin
      tests_failed++;
      $display("FAIL hit7_result got result=%0d steps=%0d want result=7 steps=1", result_w[0], steps_w[0]);
    end
    tests_run++;
    if (cyc != 2 || busy_cnt != 1) begin
      tests_failed++;
      $display("FAIL hit7_timing got cycles=%0d busy=%0d want cycles=2 busy=1", cyc, busy_cnt);
    end
  endtask

  task automatic test_max();
    logic [3:0] e[$];
    e = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
    target_v[0] = 4'd15;
    do_search(0, 1'b0);
    tests_run++;
    if ({first_done, first_found, first_result} !== 6'd0) begin
      tests_failed++;
      $display("FAIL max_restart_clear got done=%0b found=%0b result=%0d want 0,0,0", first_done, first_found, first_result);
    end
    tests_run++;
    if (gseen.size() != e.size()) begin
      tests_failed++;
      $display("FAIL max_seq_len got %0d want %0d", gseen.size(), e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        tests_run++;
        if (gseen[i] !== e[i]) begin
          tests_failed++;
          $display("FAIL max_seq[%0d] got %0d want %0d", i, gseen[i], e[i]);
        end
      end
    end
    tests_run++;
    if (found_w[0] !== 1'b1 || result_w[0] !== 4'd15 || steps_w[0] !== 3'd5 || cyc != 6) begin
      tests_failed++;
      $display("FAIL max_result got found=%0b result=%0d steps=%0d cycles=%0d want 1,15,5,6", found_w[0], result_w[0], steps_w[0], cyc);
    end
  endtask

  task automatic test_min_underflow();
    logic [3:0] e[$];
    e = '{4'd7, 4'd3, 4'd1, 4'd0};
    target_v[0] = 4'd0;
    do_search(0, 1'b0);
    tests_run++;
    if (gseen.size() != e.size()) begin
      tests_failed++;
      $display("FAIL min_seq_len got %0d want %0d", gseen.size(), e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        tests_run++;
        if (gseen[i] !== e[i]) begin
          tests_failed++;
          $display("FAIL min_seq[%0d] got %0d want %0d", i, gseen[i], e[i]);
        end
      end
    end
    tests_run++;
    if (found_w[0] !== 1'b1 || result_w[0] !== 4'd0 || steps_w[0] !== 3'd4 || cyc != 5) begin
      tests_failed++;
      $display("FAIL min_result got found=%0b result=%0d steps=%0d cycles=%0d want 1,0,4,5", found_w[0], result_w[0], steps_w[0], cyc);
    end
    force_zero[0] = 1'b1;
    do_search(0, 1'b0);
    force_zero[0] = 1'b0;
    tests_run++;
    if ({done_w[0], found_w[0], err_w[0]} !== 3'b100 || guess_w[0] !== 4'd0 || steps_w[0] !== 3'd4) begin
      tests_failed++;
      $display("FAIL underflow got done/found/err=%b guess=%0d steps=%0d want 100,0,4",
               {done_w[0], found_w[0], err_w[0]}, guess_w[0], steps_w[0]);
    end
  endtask

  task automatic test_overflow();
    force_all[0] = 1'b1;
    force_val[0] = 3'b010;
    do_search(0, 1'b0);
    force_all[0] = 1'b0;
    tests_run++;
    if ({done_w[0], found_w[0], err_w[0]} !== 3'b100 || guess_w[0] !== 4'd15 || steps_w[0] !== 3'd5 || cyc != 6) begin
      tests_failed++;
      $display("FAIL overflow got done/found/err=%b guess=%0d steps=%0d cycles=%0d want 100,15,5,6",
               {done_w[0], found_w[0], err_w[0]}, guess_w[0], steps_w[0], cyc);
    end
  endtask

  task automatic test_flag_error();
    logic [2:0] pats[2];
    pats[0] = 3'b110;
    pats[1] = 3'b000;
    for (int p = 0; p < 2; p++) begin
      force_all[0] = 1'b1;
      force_val[0] = pats[p];
      do_search(0, 1'b0);
      force_all[0] = 1'b0;
      tests_run++;
      if ({done_w[0], found_w[0], err_w[0]} !== 3'b101 || steps_w[0] !== 3'd1 || result_w[0] !== 4'd0 || cyc != 2) begin
        tests_failed++;
        $display("FAIL flag_err flags=%b got done/found/err=%b steps=%0d result=%0d cycles=%0d want 101,1,0,2",
                 pats[p], {done_w[0], found_w[0], err_w[0]}, steps_w[0], result_w[0], cyc);
      end
    end
  endtask

  task automatic test_settle();
    logic [3:0] e[$];
    e = '{4'd7, 4'd7, 4'd7, 4'd11, 4'd11, 4'd11, 4'd9, 4'd9, 4'd9, 4'd10, 4'd10, 4'd10};
    target_v[1] = 4'd10;
    do_search(1, 1'b1);
    tests_run++;
    if (gseen.size() != e.size()) begin
      tests_failed++;
      $display("FAIL settle_seq_len got %0d want %0d", gseen.size(), e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        tests_run++;
        if (gseen[i] !== e[i]) begin
          tests_failed++;
          $display("FAIL settle_seq[%0d] got %0d want %0d", i, gseen[i], e[i]);
        end
      end
    end
    tests_run++;
    if (found_w[1] !== 1'b1 || result_w[1] !== 4'd10 || steps_w[1] !== 3'd4 || cyc != 13 || busy_cnt != 12) begin
      tests_failed++;
      $display("FAIL settle_result got found=%0b result=%0d steps=%0d cycles=%0d busy=%0d want 1,10,4,13,12",
               found_w[1], result_w[1], steps_w[1], cyc, busy_cnt);
    end
  endtask

  task automatic test_reset_mid_search();
    int w;
    target_v[0] = 4'd15;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    w = 0;
    while (guess_w[0] !== 4'd13 && w < 20) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (guess_w[0] !== 4'd13 || busy_w[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reach_probe3 got guess=%0d busy=%0b want 13,1", guess_w[0], busy_w[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({guess_w[0], result_w[0], steps_w[0], busy_w[0], done_w[0], found_w[0], err_w[0]} !== 15'd0) begin
      tests_failed++;
      $display("FAIL mid_reset got guess=%0d result=%0d steps=%0d busy=%0b done=%0b found=%0b err=%0b want all 0",
               guess_w[0], result_w[0], steps_w[0], busy_w[0], done_w[0], found_w[0], err_w[0]);
    end
    rst = 1'b0;
    $display("[TB] reset applied mid-search on probe 3");
    target_v[0] = 4'd7;
    do_search(0, 1'b0);
    tests_run++;
    if (gseen.size() != 1 || found_w[0] !== 1'b1 || result_w[0] !== 4'd7 || steps_w[0] !== 3'd1 || cyc != 2) begin
      tests_failed++;
      $display("FAIL restart_after_reset got probes=%0d found=%0b result=%0d steps=%0d cycles=%0d want 1,1,7,1,2",
               gseen.size(), found_w[0], result_w[0], steps_w[0], cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i]    = 1'b0;
      target_v[i]   = 4'd0;
      force_all[i]  = 1'b0;
      force_val[i]  = 3'b000;
      force_zero[i] = 1'b0;
    end
    test_reset();
    test_first_hit();
    test_max();
    test_min_underflow();
    test_overflow();
    test_flag_error();
    test_settle();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
